// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-timer controller slice:
// timer FSM states, LFSR feedback taps and the BCD score width.
package rt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } rt_state_t;

  // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // BCD score width shared with the controller and the BCD counter
  localparam int RT_SCORE_W = 12;

endpackage

// File: rtl/random_delay_timer_if.sv
// Handshake between the reaction-timer controller (master) and the
// random delay timer (slave).
interface random_delay_timer_if;
  logic        en;
  logic        react;
  logic        downcount;
  logic        busy;
  logic [15:0] remaining_ms;
  logic        false_start;

  modport master (
    output en, react,
    input  downcount, busy, remaining_ms, false_start
  );

  modport slave (
    input  en, react,
    output downcount, busy, remaining_ms, false_start
  );
endinterface

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit Galois LFSR with optional bit-0 entropy mixing.
// A next state of zero would lock the register, so it is replaced by seed.
module rt_lfsr16
  import rt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        mix_in,
  input  logic        mix_en,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic [15:0] step_next;
  logic [15:0] mixed_next;
  logic [15:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_step
      if (gi == 15) begin : g_top
        assign step_next[gi] = LFSR_TAPS[gi] & q_reg[0];
      end else begin : g_mid
        assign step_next[gi] = q_reg[gi+1] ^ (LFSR_TAPS[gi] & q_reg[0]);
      end
    end
  endgenerate

  assign mixed_next = {step_next[15:1], step_next[0] ^ (mix_in & mix_en)};
  assign q_next     = (mixed_next == 16'h0000) ? seed : mixed_next;

  // Advance every clock; reset reloads the seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_reg <= seed;
    else       q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/random_delay_timer.sv
// Random delay timer: on a rising en it loads MIN_MS + random span and
// counts it down on a CLK_HZ/TICK_HZ prescaled tick, then holds downcount
// until en drops. Optional macro FALSE_START_EN adds a synchronised
// early-press abort (false_start pulse) and mixes the button into the LFSR.
module random_delay_timer
  import rt_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          TICK_HZ    = 1000,
  parameter int          MIN_MS     = 1000,
  parameter int          RANGE_BITS = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                 clk,
  input logic                 reset,
  random_delay_timer_if.slave bus
);

  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAX_DELAY = MIN_MS + (2 ** RANGE_BITS) - 1;

  generate
    if (DIV < 2) begin : g_chk_div
      $error("random_delay_timer: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (RANGE_BITS < 1 || RANGE_BITS > 15) begin : g_chk_range
      $error("random_delay_timer: RANGE_BITS must be within 1..15");
    end
    if (MAX_DELAY > 65535) begin : g_chk_width
      $error("random_delay_timer: MIN_MS + 2**RANGE_BITS - 1 exceeds 16 bits");
    end
    if (LFSR_SEED == 16'h0000) begin : g_chk_seed
      $error("random_delay_timer: LFSR_SEED must be non-zero");
    end
  endgenerate

  rt_state_t   state_reg;
  logic [15:0] count_reg;
  logic [PW-1:0] presc_reg;
  logic        en_q_reg;
  logic        downcount_reg;
  logic        busy_reg;
  logic [15:0] lfsr_q;
  logic [15:0] load_val;
  logic        mix_in;
  logic        mix_en;
  logic        press_abort;
  logic        unused_lfsr;

`ifdef FALSE_START_EN
  logic [1:0] sync_reg;
  logic       react_s;
  logic       false_start_reg;

  // Two-flop synchroniser for the asynchronous active-low button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], bus.react};
  end

  assign react_s     = sync_reg[1];
  assign mix_in      = react_s;
  assign mix_en      = 1'b1;
  assign press_abort = ~react_s;

  // One-clock pulse following an early-press abort edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) false_start_reg <= 1'b0;
    else       false_start_reg <= (state_reg == COUNT) && bus.en && !react_s;
  end

  assign bus.false_start = false_start_reg;
`else
  logic unused_react;
  assign unused_react    = bus.react;
  assign mix_in          = 1'b0;
  assign mix_en          = 1'b0;
  assign press_abort     = 1'b0;
  assign bus.false_start = 1'b0;
`endif

  rt_lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed   (LFSR_SEED),
    .mix_in (mix_in),
    .mix_en (mix_en),
    .q      (lfsr_q)
  );

  // Only the low RANGE_BITS feed the delay; the rest just keep the sequence long
  assign unused_lfsr = ^lfsr_q[15:RANGE_BITS];
  assign load_val    = 16'(MIN_MS) + 16'(lfsr_q[RANGE_BITS-1:0]);

  // Timer FSM: start-edge load, prescaled countdown, expired hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= 16'd0;
      presc_reg     <= '0;
      en_q_reg      <= 1'b0;
      downcount_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      en_q_reg <= bus.en;
      case (state_reg)
        IDLE: begin
          if (bus.en && !en_q_reg) begin
            count_reg <= load_val;
            presc_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= COUNT;
          end
        end
        COUNT: begin
          if (!bus.en || press_abort) begin
            count_reg <= 16'd0;
            presc_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (presc_reg == PW'(DIV - 1)) begin
            presc_reg <= '0;
            if (count_reg <= 16'd1) begin
              count_reg     <= 16'd0;
              busy_reg      <= 1'b0;
              downcount_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              count_reg <= count_reg - 16'd1;
            end
          end else begin
            presc_reg <= presc_reg + PW'(1);
          end
        end
        DONE: begin
          if (!bus.en) begin
            downcount_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.downcount    = downcount_reg;
  assign bus.busy         = busy_reg;
  assign bus.remaining_ms = count_reg;

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with DIV=10, MIN_MS=3, RANGE_BITS=1.
// Expected delays come from an independent reference LFSR.
module tb_random_delay_timer;
  import rt_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  random_delay_timer_if bus_if ();

  random_delay_timer #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .MIN_MS     (3),
    .RANGE_BITS (1),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR
  logic [15:0] m_lfsr;
  logic        m_s1;
  logic        m_s2;

  function automatic logic [15:0] model_next(input logic [15:0] s, input logic mixbit);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    n[0] = n[0] ^ mixbit;
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_s1   <= 1'b1;
      m_s2   <= 1'b1;
    end else begin
      m_s1 <= bus_if.react;
      m_s2 <= m_s1;
`ifdef FALSE_START_EN
      m_lfsr <= model_next(m_lfsr, m_s2);
`else
      m_lfsr <= model_next(m_lfsr, 1'b0);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ms;
    int n;
    int found;
    int busy_lo;
    int dc_lo;
    int dc_hi;
    int fs_hi;

    reset = 1'b0;
    bus_if.en = 1'b0;
    bus_if.react = 1'b1;
    #2 reset = 1'b1;
    step(); step(); step();

    // Reset state
    chk("rst_downcount", 32'(bus_if.downcount), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_remaining", 32'(bus_if.remaining_ms), 0);
    chk("rst_false_start", 32'(bus_if.false_start), 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    $display("reset: outputs=%b%b%b remaining=%0d", bus_if.downcount, bus_if.busy,
             bus_if.false_start, bus_if.remaining_ms);
    reset = 1'b0;
    step(); step(); step();

    // Full run to expiry
    exp_ms = 3 + int'(m_lfsr[0]);
    bus_if.en = 1'b1;
    step();
    chk("load_val", 32'(bus_if.remaining_ms), 32'(exp_ms));
    chk("load_busy", 32'(bus_if.busy), 1);
    chk("load_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
    n = 0; found = 0; busy_lo = 0;
    for (int i = 1; i <= 60 && found == 0; i++) begin
      step();
      if (bus_if.downcount) begin
        found = 1;
        n = i;
      end else if (!bus_if.busy) begin
        busy_lo++;
      end
    end
    chk("run_delay", 32'(n), 32'(exp_ms * 10));
    chk("run_busy_fall", 32'(bus_if.busy), 0);
    chk("run_busy_hold", 32'(busy_lo), 0);
    chk("run_remaining", 32'(bus_if.remaining_ms), 0);
    $display("run: loaded=%0d downcount after %0d clocks", exp_ms, n);

    // DONE hold then release
    dc_lo = 0;
    repeat (25) begin
      step();
      if (!bus_if.downcount) dc_lo++;
    end
    chk("done_hold", 32'(dc_lo), 0);
    bus_if.en = 1'b0;
    step();
    chk("done_release", 32'(bus_if.downcount), 0);
    chk("done_state", 32'(dut.state_reg), 32'(IDLE));
    $display("done: held 25 clocks, released downcount=%b", bus_if.downcount);

    // Abort at clock 15 of COUNT
    step();
    exp_ms = 3 + int'(m_lfsr[0]);
    bus_if.en = 1'b1;
    step();
    chk("abort_load", 32'(bus_if.remaining_ms), 32'(exp_ms));
    repeat (14) step();
    bus_if.en = 1'b0;
    step();
    chk("abort_busy", 32'(bus_if.busy), 0);
    chk("abort_remaining", 32'(bus_if.remaining_ms), 0);
    chk("abort_state", 32'(dut.state_reg), 32'(IDLE));
    dc_hi = 0;
    repeat (50) begin
      step();
      if (bus_if.downcount) dc_hi++;
    end
    chk("abort_no_downcount", 32'(dc_hi), 0);
    $display("abort: busy=%b remaining=%0d downcount_highs=%0d", bus_if.busy,
             bus_if.remaining_ms, dc_hi);

    // Asynchronous reset mid-COUNT with en held high
    bus_if.en = 1'b1;
    step();
    chk("rmid_busy", 32'(bus_if.busy), 1);
    repeat (11) step();
    #2 reset = 1'b1;
    #1;
    chk("rmid_downcount", 32'(bus_if.downcount), 0);
    chk("rmid_busy_async", 32'(bus_if.busy), 0);
    chk("rmid_remaining", 32'(bus_if.remaining_ms), 0);
    chk("rmid_false_start", 32'(bus_if.false_start), 0);
    chk("rmid_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    step();
    reset = 1'b0;
    step();
    chk("rmid_reload", 32'(bus_if.remaining_ms), 4);
    chk("rmid_reload_busy", 32'(bus_if.busy), 1);
    $display("reset-mid: async clear, reload=%0d", bus_if.remaining_ms);

    // 1000 back-to-back loads
    bus_if.en = 1'b0;
    step();
    for (int k = 0; k < 1000; k++) begin
      exp_ms = 3 + int'(m_lfsr[0]);
      chk("seq_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
      bus_if.en = 1'b1;
      step();
      chk("seq_load", 32'(bus_if.remaining_ms), 32'(exp_ms));
      chk("seq_range", 32'(bus_if.remaining_ms >= 16'd3 && bus_if.remaining_ms <= 16'd4), 1);
      chk("seq_lfsr_nonzero", 32'(dut.lfsr_q != 16'h0000), 1);
      $display("load %0d: delay=%0d lfsr=%04h", k, bus_if.remaining_ms, dut.lfsr_q);
      bus_if.en = 1'b0;
      step();
    end

    // Early press at clock 8 of COUNT
    exp_ms = 3 + int'(m_lfsr[0]);
    bus_if.en = 1'b1;
    step();
    chk("fs_load", 32'(bus_if.remaining_ms), 32'(exp_ms));
    repeat (7) step();
    bus_if.react = 1'b0;
`ifdef FALSE_START_EN
    step();
    chk("fs_pulse_c1", 32'(bus_if.false_start), 0);
    step();
    chk("fs_pulse_c2", 32'(bus_if.false_start), 0);
    step();
    chk("fs_pulse_c3", 32'(bus_if.false_start), 1);
    chk("fs_state", 32'(dut.state_reg), 32'(IDLE));
    chk("fs_remaining", 32'(bus_if.remaining_ms), 0);
    step();
    chk("fs_pulse_end", 32'(bus_if.false_start), 0);
    chk("fs_downcount", 32'(bus_if.downcount), 0);
    $display("false-start: pulse seen, state=%0d", dut.state_reg);
`else
    n = 0; found = 0; fs_hi = 0;
    for (int i = 8; i <= 60 && found == 0; i++) begin
      step();
      if (bus_if.false_start) fs_hi++;
      if (bus_if.downcount) begin
        found = 1;
        n = i;
      end
    end
    chk("press_run_delay", 32'(n), 32'(exp_ms * 10));
    chk("press_no_false_start", 32'(fs_hi), 0);
    $display("press ignored: loaded=%0d downcount after %0d clocks", exp_ms, n);
`endif
    bus_if.react = 1'b1;
    bus_if.en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_delay_timer.md
Name: random_delay_timer

Overview:
- Upstream stage of the reaction-timer controller; implements the controller's "random" phase.
- The controller holds `en` high while in its random state. This block then loads a pseudo-random delay in milliseconds and counts it down on a 1 ms tick.
- When the delay expires it raises `downcount`, which moves the controller to its reaction state.
- A free-running 16-bit LFSR supplies the randomness; user press timing provides the entropy.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1000, countdown tick rate; DIV = CLK_HZ/TICK_HZ clocks per tick, DIV >= 2.
- MIN_MS, 1000, minimum delay in ticks.
- RANGE_BITS, 12, random span: delay = MIN_MS + lfsr[RANGE_BITS-1:0]; 1 <= RANGE_BITS <= 15.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- en, input, 1, level enable from the controller's random state.
- react, input, 1, raw active-low push button. Used only with FALSE_START_EN.
- downcount, output, 1, delay-expired level.
- busy, output, 1, high while counting.
- remaining_ms, output, 16, current countdown value.
- false_start, output, 1, early-press pulse. Tied 0 without FALSE_START_EN.

Behaviour:
- Reset (async, active-high) forces: state IDLE, count 0, prescaler 0, lfsr = LFSR_SEED, en_q 0, downcount 0, busy 0, false_start 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clock in every state and can never reach zero.
- en_q is en registered one clock. A start edge is a posedge where en=1 and en_q=0.
  - en held high through reset release starts a run on the first clock after release.
- IDLE:
  - On a start edge: count <= MIN_MS + lfsr[RANGE_BITS-1:0], using the lfsr value before that edge's update. Prescaler <= 0, state -> COUNT.
- COUNT:
  - busy = 1, remaining_ms = count.
  - Prescaler counts 0..DIV-1 and wraps; the tick occurs at the edge where prescaler = DIV-1.
  - On a tick: if count == 1, count <= 0 and state -> DONE; otherwise count <= count-1.
  - downcount therefore rises exactly count_loaded*DIV clocks after the load edge.
  - en = 0 in COUNT aborts: state -> IDLE, count <= 0, prescaler <= 0, downcount stays 0.
- DONE:
  - downcount = 1, busy = 0, remaining_ms = 0.
  - downcount holds high while en = 1. en = 0 -> IDLE, and downcount is low on the next cycle.
- A start edge is only honoured in IDLE. en toggling inside one cycle is not supported.
- Width: MIN_MS + 2^RANGE_BITS - 1 must be <= 65535. Violation fails elaboration via a generate-time check.
- Outputs are registered (downcount, busy) or come directly from the count register. No combinational input-to-output paths.
- Reset mid-COUNT or mid-DONE returns to the reset values immediately, asynchronously.

Optional Feature:
- Macro FALSE_START_EN.
- Defined:
  - react passes through a 2-flop synchroniser to give react_s.
  - In COUNT, react_s = 0 aborts the run: state -> IDLE, count <= 0.
  - false_start pulses high for exactly one clock, on the cycle after the abort edge.
  - On every clock, react_s is XORed into lfsr bit 0 for extra entropy. Any XOR result that would make the LFSR zero is replaced with LFSR_SEED.
- Undefined: react is unused (no synchroniser), false_start is constant 0, LFSR is unmixed.

Decomposition:
- Shared package rt_pkg holds:
  - state enum {IDLE, COUNT, DONE} (2 bits);
  - LFSR_TAPS = 16'hB400;
  - RT_SCORE_W = 12, the BCD score width shared with the controller and BCD counter.
- One sub-module, rt_lfsr16:
  - ports clk, reset, seed, mix_in, mix_en, q;
  - all LFSR logic, including zero-state recovery.
- Top level holds the prescaler, countdown and FSM.

Test Plan:
- Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), MIN_MS=3, RANGE_BITS=1.
  - Assert en after reset. remaining_ms loads 3+lfsr[0] (3 or 4, checked against a model LFSR).
  - downcount rises exactly 30 or 40 clocks after the load edge; busy falls on the same edge.
- DONE hold: keep en high for 25 clocks after downcount rises -> downcount stays 1. Drop en -> downcount 0 next clock, state IDLE.
- Abort: drop en at clock 15 of COUNT -> busy 0 next clock, downcount never rises, remaining_ms 0.
- Reset mid-COUNT: pulse reset at clock 12 -> all outputs 0 asynchronously and lfsr = 16'hACE1. en still high after release -> new run loads on the first clock.
- Run 1000 back-to-back loads:
  - each delay lies in [MIN_MS, MIN_MS + 2^RANGE_BITS - 1];
  - lfsr never reads 0;
  - sequence matches the model.
- FALSE_START_EN defined: drive react low at clock 8 of COUNT -> false_start high for one clock 3 clocks later (2 sync + 1), state IDLE, downcount stays 0. Undefined: same stimulus -> countdown completes normally.
